// File: rtl/substitui_bytes_seq.sv
// Sequential AES SubBytes: substitutes a 128-bit state LANES bytes per clock.
// Build macro SUBSTITUI_DIRETA_EN adds the direct S-box and honours modo; otherwise inverse only.
module substitui_bytes_seq #(
  parameter int LANES       = 4,
  parameter bit MODO_PADRAO = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         entrada_valida,
  output logic         entrada_pronta,
  input  logic [127:0] bloco,
  input  logic         modo,
  output logic [127:0] saida,
  output logic         saida_valida,
  input  logic         saida_pronta,
  output logic         ocupado
);

  localparam int PASSOS = 16 / LANES;
  localparam int CW     = (PASSOS > 1) ? $clog2(PASSOS) : 1;
  localparam logic [CW-1:0] ULTIMO = CW'(PASSOS - 1);

  generate
    if (LANES < 1 || LANES > 16 || (16 % LANES) != 0) begin : g_lanes_invalido
      $error("substitui_bytes_seq: LANES must divide 16 (1, 2, 4, 8 or 16)");
    end
  endgenerate

  // Index 0 is the leftmost byte of each table.
  localparam logic [0:255][7:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

`ifdef SUBSTITUI_DIRETA_EN
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };
`endif

  typedef enum logic [1:0] {OCIOSO, PROCESSA, ENTREGA} estado_t;

  estado_t         estado;
  logic [CW-1:0]   cnt;
  logic [127:0]    trabalho;
  logic [127:0]    proximo;
  logic            modo_r;

  always_comb begin
    int  base;
    logic [7:0] entra;
    proximo = trabalho;
    entra   = '0;
    base    = int'(cnt) * LANES;
    for (int l = 0; l < LANES; l++) begin
      entra = trabalho[8*(base+l) +: 8];
`ifdef SUBSTITUI_DIRETA_EN
      proximo[8*(base+l) +: 8] = modo_r ? INV_SBOX[entra] : SBOX[entra];
`else
      proximo[8*(base+l) +: 8] = INV_SBOX[entra];
`endif
    end
  end

`ifndef SUBSTITUI_DIRETA_EN
  // modo is kept on the port and latched for a uniform reset image, but has no effect here.
  logic unused_modo;
  assign unused_modo = modo ^ modo_r;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado         <= OCIOSO;
      cnt            <= '0;
      trabalho       <= '0;
      modo_r         <= MODO_PADRAO;
      saida_valida   <= 1'b0;
      entrada_pronta <= 1'b1;
      ocupado        <= 1'b0;
    end else begin
      case (estado)
        OCIOSO: begin
          if (entrada_valida) begin
            trabalho       <= bloco;
`ifdef SUBSTITUI_DIRETA_EN
            modo_r         <= modo;
`endif
            cnt            <= '0;
            estado         <= PROCESSA;
            entrada_pronta <= 1'b0;
            ocupado        <= 1'b1;
          end
        end
        PROCESSA: begin
          trabalho <= proximo;
          if (cnt == ULTIMO) begin
            estado       <= ENTREGA;
            saida_valida <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ENTREGA: begin
          // No bypass: the next accept can only happen once back in OCIOSO.
          if (saida_pronta) begin
            estado         <= OCIOSO;
            saida_valida   <= 1'b0;
            ocupado        <= 1'b0;
            entrada_pronta <= 1'b1;
          end
        end
        default: begin
          estado         <= OCIOSO;
          saida_valida   <= 1'b0;
          ocupado        <= 1'b0;
          entrada_pronta <= 1'b1;
        end
      endcase
    end
  end

  assign saida = trabalho;

endmodule

// File: tb/tb_substitui_bytes_seq.sv
// Bench for substitui_bytes_seq: four instances (LANES 4, 1, 16, 2) share one stimulus stream.
module tb_substitui_bytes_seq;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         entrada_valida;
  logic [127:0] bloco;
  logic         modo;
  logic         saida_pronta;

  logic [127:0] saida_o [4];
  logic         val_o   [4];
  logic         pronta_o[4];
  logic         ocup_o  [4];

  localparam int LAT[4] = '{4, 16, 1, 8};

  int n_cmp  = 0;
  int n_fail = 0;
  int ocup_cnt;

  always #5 clk = ~clk;

  substitui_bytes_seq #(.LANES(4)) u_l4 (
    .clk(clk), .rst_n(rst_n), .entrada_valida(entrada_valida), .entrada_pronta(pronta_o[0]),
    .bloco(bloco), .modo(modo), .saida(saida_o[0]), .saida_valida(val_o[0]),
    .saida_pronta(saida_pronta), .ocupado(ocup_o[0]));
  substitui_bytes_seq #(.LANES(1)) u_l1 (
    .clk(clk), .rst_n(rst_n), .entrada_valida(entrada_valida), .entrada_pronta(pronta_o[1]),
    .bloco(bloco), .modo(modo), .saida(saida_o[1]), .saida_valida(val_o[1]),
    .saida_pronta(saida_pronta), .ocupado(ocup_o[1]));
  substitui_bytes_seq #(.LANES(16)) u_l16 (
    .clk(clk), .rst_n(rst_n), .entrada_valida(entrada_valida), .entrada_pronta(pronta_o[2]),
    .bloco(bloco), .modo(modo), .saida(saida_o[2]), .saida_valida(val_o[2]),
    .saida_pronta(saida_pronta), .ocupado(ocup_o[2]));
  substitui_bytes_seq #(.LANES(2)) u_l2 (
    .clk(clk), .rst_n(rst_n), .entrada_valida(entrada_valida), .entrada_pronta(pronta_o[3]),
    .bloco(bloco), .modo(modo), .saida(saida_o[3]), .saida_valida(val_o[3]),
    .saida_pronta(saida_pronta), .ocupado(ocup_o[3]));

  typedef struct {
    string        nome;
    logic [127:0] bloco;
    logic         modo;
    logic [127:0] esperado;
  } vetor_t;

  vetor_t vetores[6];

  task automatic check(input string nome, input int idx, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s[dut%0d]: got %h required %h", nome, idx, got, exp);
    end
  endtask

  // Accept edge already passed and sampled; watch every instance for its result.
  task automatic collect(input string nome, input logic [127:0] exp);
    int           lat [4];
    logic [127:0] got [4];
    for (int d = 0; d < 4; d++) begin
      lat[d] = 0;
      got[d] = '0;
    end
    for (int j = 1; j <= 20; j++) begin
      @(posedge clk); #1;
      for (int d = 0; d < 4; d++)
        if (lat[d] == 0 && val_o[d]) begin
          lat[d] = j;
          got[d] = saida_o[d];
        end
      if (j <= 15 && ocup_o[1] && !val_o[1]) ocup_cnt++;
    end
    for (int d = 0; d < 4; d++) begin
      check({nome, "_lat"}, d, 128'(lat[d]), 128'(LAT[d]));
      check({nome, "_data"}, d, got[d], exp);
    end
    check({nome, "_ocupado16"}, 1, 128'(ocup_cnt), 128'd16);
  endtask

  task automatic accept(input logic [127:0] blk, input logic md);
    int w = 0;
    while (!(pronta_o[0] && pronta_o[1] && pronta_o[2] && pronta_o[3]) && w < 40) begin
      @(posedge clk); #1;
      w++;
    end
    check("ready_wait", 0, 128'(w < 40), 128'd1);
    bloco = blk;
    modo = md;
    entrada_valida = 1'b1;
    @(posedge clk); #1;
    entrada_valida = 1'b0;
    ocup_cnt = (ocup_o[1] && !val_o[1]) ? 1 : 0;
  endtask

  initial begin
    vetores[0] = '{"all63", {16{8'h63}}, 1'b1, {16{8'h00}}};
    vetores[1] = '{"b0_00_rest7c", {{15{8'h7c}}, 8'h00}, 1'b1, {{15{8'h01}}, 8'h52}};
    vetores[2] = '{"row0", 128'h0f0e0d0c0b0a09080706050403020100, 1'b1,
                   128'hfbd7f3819ea340bf38a53630d56a0952};
    vetores[3] = '{"allff", {16{8'hff}}, 1'b1, {16{8'h7d}}};
    vetores[4] = '{"modo0_00_01_53", {{13{8'h53}}, 8'h53, 8'h01, 8'h00}, 1'b0,
                   {{13{8'h50}}, 8'h50, 8'h09, 8'h52}};
    vetores[5] = '{"row15", 128'hfffefdfcfbfaf9f8f7f6f5f4f3f2f1f0, 1'b1,
                   128'h7d0c2155631469e126d677ba7e042b17};

    rst_n = 1'b0;
    entrada_valida = 1'b0;
    bloco = '0;
    modo = 1'b1;
    saida_pronta = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 4; d++) begin
      check("rst_saida", d, saida_o[d], '0);
      check("rst_valida", d, 128'(val_o[d]), 128'd0);
      check("rst_ocupado", d, 128'(ocup_o[d]), 128'd0);
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    for (int d = 0; d < 4; d++) check("rst_pronta", d, 128'(pronta_o[d]), 128'd1);

    for (int v = 0; v < 6; v++) begin
      accept(vetores[v].bloco, vetores[v].modo);
      collect(vetores[v].nome, vetores[v].esperado);
    end

    // Backpressure: result held, new data offered, then released.
    saida_pronta = 1'b0;
    accept(vetores[2].bloco, 1'b1);
    collect("hold_first", vetores[2].esperado);
    entrada_valida = 1'b1;
    bloco = vetores[5].bloco;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      check("hold_saida", 0, saida_o[0], vetores[2].esperado);
      check("hold_valida", 0, 128'(val_o[0]), 128'd1);
      check("hold_pronta", 0, 128'(pronta_o[0]), 128'd0);
    end
    saida_pronta = 1'b1;
    @(posedge clk); #1;
    check("release_valida", 0, 128'(val_o[0]), 128'd0);
    check("release_pronta", 0, 128'(pronta_o[0]), 128'd1);
    check("release_retain", 0, saida_o[0], vetores[2].esperado);
    check("release_ocupado", 0, 128'(ocup_o[0]), 128'd0);
    @(posedge clk); #1;
    entrada_valida = 1'b0;
    check("next_accept_ocupado", 0, 128'(ocup_o[0]), 128'd1);
    check("next_accept_pronta", 0, 128'(pronta_o[0]), 128'd0);
    ocup_cnt = (ocup_o[1] && !val_o[1]) ? 1 : 0;
    collect("after_release", vetores[5].esperado);

    // Reset in the middle of processing (LANES=2 instance at counter 2).
    accept(vetores[3].bloco, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    for (int d = 0; d < 4; d++) begin
      check("abort_saida", d, saida_o[d], '0);
      check("abort_valida", d, 128'(val_o[d]), 128'd0);
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    for (int d = 0; d < 4; d++) check("abort_pronta", d, 128'(pronta_o[d]), 128'd1);
    accept(vetores[1].bloco, 1'b1);
    collect("after_abort", vetores[1].esperado);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
